floor_request_queue: RTL and testbench

FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/floor_scan_select.sv | 55 +++++
 rtl/floor_request_queue.sv | 113 +++++++++++
 tb/tb_floor_request_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants and helpers: default floor count, direction codes,
// reset floor, and a one-hot validity check used on keypad and driver inputs.
// Pure package, no timing; no flow control.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 4;
  localparam int MAX_FLOORS     = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Floor 0 (LSB); slice down to the instance's floor width.
  localparam logic [MAX_FLOORS-1:0] FLOOR_RESET = 16'h0001;

  // Callers zero-extend narrower floor vectors to MAX_FLOORS bits.
  function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/floor_scan_select.sv
// SCAN destination picker: nearest queued floor strictly ahead in dir, else nearest behind.
// Combinational, zero latency; no flow control.
// Ports: slot/slot_vld = queue contents, cur_floor/dir = car state, des = chosen floor (all-ones if empty).
module floor_scan_select #(
  parameter int NUM_FLOORS = 4,
  parameter int DEPTH      = 4
) (
  input  logic [DEPTH-1:0][NUM_FLOORS-1:0] slot,
  input  logic [DEPTH-1:0]                 slot_vld,
  input  logic [NUM_FLOORS-1:0]            cur_floor,
  input  logic                             dir,
  output logic [NUM_FLOORS-1:0]            des
);

  logic [NUM_FLOORS-1:0] qmask, below, above, up_cand, dn_cand, up_near, dn_near, ahead, behind;

  always_comb begin
    qmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) qmask = qmask | slot[i];
    end

    // cur_floor is one-hot, so cur-1 marks every floor beneath it.
    below   = cur_floor - {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    above   = ~(below | cur_floor);
    up_cand = qmask & above;
    dn_cand = qmask & below;

    // Nearest above is the lowest set bit; nearest below is the highest.
    up_near = '0;
    for (int i = NUM_FLOORS-1; i >= 0; i--) begin
      if (up_cand[i]) begin
        up_near    = '0;
        up_near[i] = 1'b1;
      end
    end
    dn_near = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (dn_cand[i]) begin
        dn_near    = '0;
        dn_near[i] = 1'b1;
      end
    end

    ahead  = dir ? up_near : dn_near;
    behind = dir ? dn_near : up_near;

    // Only the current floor queued (awaiting removal): point at it so go stays low.
    if (ahead != '0)       des = ahead;
    else if (behind != '0) des = behind;
    else if (qmask != '0)  des = cur_floor;
    else                   des = '1;
  end

endmodule

// File: rtl/floor_request_queue.sv
// Elevator floor request queue with FIFO or SCAN destination selection and car position tracking.
// Latency: accepted request visible one cycle after the edge; serviced floor removed on the edge it matches cur_floor.
// Backpressure: none; a valid new request with no free slot is dropped and flagged by a registered one-cycle drop pulse.
// Ports: enable/key_code = keypad request, clear = flush, step_tick/new_floor = car movement,
//        cur_floor/dir = registered car state, des/go = driver command, count/full/drop = queue status.
module floor_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int DEPTH      = 4,
  parameter int SCAN_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_FLOORS-1:0]         key_code,
  input  logic                          clear,
  input  logic                          step_tick,
  input  logic [NUM_FLOORS-1:0]         new_floor,
  output logic [NUM_FLOORS-1:0]         cur_floor,
  output logic [NUM_FLOORS-1:0]         des,
  output logic                          go,
  output logic                          dir,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          drop
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0][NUM_FLOORS-1:0] slot_q, slot_d;
  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic                             drop_d, req_ok, dup;
  logic [CW-1:0]                    kept;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(vld_q[i]);
  end
  assign full = (count == CW'(DEPTH));

  // Next queue: drop slots at cur_floor, compact survivors toward slot 0 in
  // order, then append the new request at the resulting tail.
  always_comb begin
    slot_d = '0;
    vld_d  = '0;
    kept   = '0;
    drop_d = 1'b0;
    req_ok = enable && is_onehot(MAX_FLOORS'(key_code));
    dup    = (key_code == cur_floor);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (slot_q[i] == key_code)) dup = 1'b1;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (slot_q[i] != cur_floor)) begin
        slot_d[kept[IW-1:0]] = slot_q[i];
        vld_d[kept[IW-1:0]]  = 1'b1;
        kept = kept + CW'(1);
      end
    end

    if (clear) begin
      vld_d = '0;
    end else if (req_ok && !dup) begin
      if (kept < CW'(DEPTH)) begin
        slot_d[kept[IW-1:0]] = key_code;
        vld_d[kept[IW-1:0]]  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q    <= '0;
      vld_q     <= '0;
      drop      <= 1'b0;
      cur_floor <= FLOOR_RESET[NUM_FLOORS-1:0];
      dir       <= DIR_UP;
    end else begin
      slot_q <= slot_d;
      vld_q  <= vld_d;
      drop   <= drop_d;
      if (step_tick && is_onehot(MAX_FLOORS'(new_floor))) cur_floor <= new_floor;
      // One-hot vectors order the same way as floor numbers.
      if (count != '0) begin
        if (des > cur_floor)      dir <= DIR_UP;
        else if (des < cur_floor) dir <= DIR_DOWN;
      end
    end
  end

  generate
    if (SCAN_MODE == 1) begin : g_scan
      floor_scan_select #(.NUM_FLOORS(NUM_FLOORS), .DEPTH(DEPTH)) u_scan (
        .slot      (slot_q),
        .slot_vld  (vld_q),
        .cur_floor (cur_floor),
        .dir       (dir),
        .des       (des)
      );
    end else begin : g_fifo
      // Valid slots are contiguous from 0, so slot 0 valid means non-empty.
      assign des = vld_q[0] ? slot_q[0] : '1;
    end
  endgenerate

  assign go = (count != '0) && (des != cur_floor);

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: FIFO and SCAN instances share stimulus; a queue-based
// reference model predicts each post-edge output set, which a monitor pops and compares.
module tb_floor_request_queue;

  localparam int NF = 8;
  localparam int DP = 4;

  logic          clk = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0, step_tick = 1'b0;
  logic [NF-1:0] key_code = '0, new_floor = '0;
  logic [NF-1:0] cur0, cur1, des0, des1;
  logic          go0, go1, dir0, dir1, full0, full1, drop0, drop1;
  logic [2:0]    cnt0, cnt1;

  always #5 clk = ~clk;

  floor_request_queue #(.NUM_FLOORS(NF), .DEPTH(DP), .SCAN_MODE(0)) u_fifo (
    .clk(clk), .reset(reset), .enable(enable), .key_code(key_code), .clear(clear),
    .step_tick(step_tick), .new_floor(new_floor), .cur_floor(cur0), .des(des0),
    .go(go0), .dir(dir0), .count(cnt0), .full(full0), .drop(drop0));

  floor_request_queue #(.NUM_FLOORS(NF), .DEPTH(DP), .SCAN_MODE(1)) u_scan (
    .clk(clk), .reset(reset), .enable(enable), .key_code(key_code), .clear(clear),
    .step_tick(step_tick), .new_floor(new_floor), .cur_floor(cur1), .des(des1),
    .go(go1), .dir(dir1), .count(cnt1), .full(full1), .drop(drop1));

  typedef struct packed {
    logic [7:0] cur, des0, des1;
    logic       go0, go1, dir0, dir1;
    logic [2:0] cnt;
    logic       full, drop;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: pending floors as indices in arrival order.
  int mq[$];
  int mcur;
  bit mdir [2];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(logic [7:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Destination floor index per mode; -1 means queue empty.
  function automatic int des_idx(int m);
    int best = -1;
    if (mq.size() == 0) return -1;
    if (m == 0) return mq[0];
    foreach (mq[i])
      if ((mdir[m] ? mq[i] > mcur : mq[i] < mcur) && (best < 0 || absd(mq[i], mcur) < absd(best, mcur)))
        best = mq[i];
    if (best < 0)
      foreach (mq[i])
        if ((mdir[m] ? mq[i] < mcur : mq[i] > mcur) && (best < 0 || absd(mq[i], mcur) < absd(best, mcur)))
          best = mq[i];
    if (best < 0) best = mcur;
    return best;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int d0 = des_idx(0);
    int d1 = des_idx(1);
    e.cur  = 8'(1 << mcur);
    e.des0 = (d0 < 0) ? 8'hFF : 8'(1 << d0);
    e.des1 = (d1 < 0) ? 8'hFF : 8'(1 << d1);
    e.go0  = (d0 >= 0) && (d0 != mcur);
    e.go1  = (d1 >= 0) && (d1 != mcur);
    e.dir0 = mdir[0];
    e.dir1 = mdir[1];
    e.cnt  = 3'(mq.size());
    e.full = (mq.size() == DP);
    e.drop = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    mcur    = 0;
    mdir[0] = 1'b1;
    mdir[1] = 1'b1;
  endtask

  task automatic model_step(bit en, logic [7:0] key, bit clr, bit tick, logic [7:0] nf, output bit dr);
    int d [2];
    int nq[$];
    int k;
    bit dup;
    d[0] = des_idx(0);
    d[1] = des_idx(1);
    dr   = 1'b0;
    if (mq.size() > 0)
      for (int m = 0; m < 2; m++) begin
        if (d[m] > mcur)      mdir[m] = 1'b1;
        else if (d[m] < mcur) mdir[m] = 1'b0;
      end
    if (clr) mq.delete();
    else begin
      foreach (mq[i]) if (mq[i] != mcur) nq.push_back(mq[i]);
      k = en ? oh_idx(key) : -1;
      if (k >= 0) begin
        dup = (k == mcur);
        foreach (mq[i]) if (mq[i] == k) dup = 1'b1;
        if (!dup) begin
          if (nq.size() < DP) nq.push_back(k);
          else dr = 1'b1;
        end
      end
      mq = nq;
    end
    if (tick && oh_idx(nf) >= 0) mcur = oh_idx(nf);
  endtask

  task automatic check_out(exp_t e, string tag);
    cmp({tag, "_cur0"},  cur0,  e.cur);
    cmp({tag, "_cur1"},  cur1,  e.cur);
    cmp({tag, "_des_fifo"}, des0, e.des0);
    cmp({tag, "_des_scan"}, des1, e.des1);
    cmp({tag, "_go_fifo"},  go0,  e.go0);
    cmp({tag, "_go_scan"},  go1,  e.go1);
    cmp({tag, "_dir_fifo"}, dir0, e.dir0);
    cmp({tag, "_dir_scan"}, dir1, e.dir1);
    cmp({tag, "_count"}, {cnt1, cnt0}, {e.cnt, e.cnt});
    cmp({tag, "_full"},  {full1, full0}, {e.full, e.full});
    cmp({tag, "_drop"},  {drop1, drop0}, {e.drop, e.drop});
  endtask

  task automatic drive(bit en, logic [7:0] key, bit clr, bit tick, logic [7:0] nf);
    exp_t e;
    bit   dr;
    @(negedge clk);
    enable = en; key_code = key; clear = clr; step_tick = tick; new_floor = nf;
    model_step(en, key, clr, tick, nf, dr);
    e      = model_out();
    e.drop = dr;
    exp_q.push_back(e);
  endtask

  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    e = model_out();
    check_out(e, "async_rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge with an outstanding prediction is checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_out(exp_q.pop_front(), "mon");
    end
  end

  initial begin
    exp_t e;
    logic [7:0] key, nf;
    bit en, clr, tick;

    #1 reset = 1'b1;
    #1;
    model_reset();
    e = model_out();
    check_out(e, "reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single request from reset.
    drive(1, 8'h04, 0, 0, 8'h00);
    // FIFO order and service of an intermediate floor.
    drive(0, 8'h00, 1, 0, 8'h00);
    drive(1, 8'h08, 0, 0, 8'h00);
    drive(1, 8'h02, 0, 0, 8'h00);
    drive(1, 8'h04, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 1, 8'h02);
    drive(0, 8'h00, 0, 0, 8'h00);
    // Duplicates, current floor, non-one-hot, disabled: all ignored.
    drive(1, 8'h04, 0, 0, 8'h00);
    drive(1, 8'h02, 0, 0, 8'h00);
    drive(1, 8'h06, 0, 0, 8'h00);
    drive(0, 8'h10, 0, 0, 8'h00);
    // Fill, overflow drop, then removal plus append in one edge.
    drive(1, 8'h10, 0, 0, 8'h00);
    drive(1, 8'h20, 0, 0, 8'h00);
    drive(1, 8'h40, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 1, 8'h10);
    drive(1, 8'h40, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 1, 8'h03);
    // Bring count to 3, then reset mid-cycle.
    drive(0, 8'h00, 0, 1, 8'h08);
    drive(0, 8'h00, 0, 0, 8'h00);
    async_reset();
    // Clear, including one that races an enqueue.
    drive(1, 8'h02, 0, 0, 8'h00);
    drive(1, 8'h04, 0, 0, 8'h00);
    drive(1, 8'h08, 1, 0, 8'h00);
    drive(0, 8'h00, 0, 0, 8'h00);
    // SCAN: car at floor 1 heading up with floors 3 and 0 pending.
    drive(0, 8'h00, 0, 1, 8'h02);
    drive(1, 8'h08, 0, 0, 8'h00);
    drive(1, 8'h01, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 1, 8'h08);
    drive(0, 8'h00, 0, 0, 8'h00);
    drive(0, 8'h00, 0, 0, 8'h00);

    // Randomized traffic; ticks often head to a pending floor so the queue drains.
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      key = ($urandom_range(0, 9) < 8) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 59) == 0);
      tick = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        nf = 8'(1 << mq[$urandom_range(0, mq.size() - 1)]);
      else if ($urandom_range(0, 7) == 0)
        nf = 8'($urandom_range(0, 255));
      else
        nf = 8'(1 << $urandom_range(0, 7));
      drive(en, key, clr, tick, nf);
    end

    drive(0, 8'h00, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
